// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the MEM stage.
// Optional watchdog compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall_pipe,
  output logic        stall_if,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, DATA, DRESP, FETCH, FRESP} state_t;

  state_t      state, state_nxt;
  logic        done;
  logic [31:0] rdata_eff;
  logic        in_access;

  assign in_access = (state == DATA) || (state == FETCH);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be nonzero");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  logic [CW-1:0] cnt;
  logic          timeout;
  logic          err_q;

  // A real mem_ready in the limit cycle wins over the watchdog.
  assign timeout   = in_access && !mem_ready && (cnt == CW'(TIMEOUT));
  assign done      = mem_ready || timeout;
  assign rdata_eff = timeout ? '0 : mem_rdata;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        cnt <= '0;
      else if (in_access && !mem_ready)
        cnt <= cnt + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign done      = mem_ready;
  assign rdata_eff = mem_rdata;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_req)      state_nxt = DATA;
        else if (if_req) state_nxt = FETCH;
      end
      DATA:    if (done) state_nxt = DRESP;
      DRESP:   state_nxt = IDLE;
      FETCH:   if (done) state_nxt = FRESP;
      FRESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
    end else begin
      dm_valid <= 1'b0;
      if_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
          end else if (if_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_be   <= '1;
          end
        end
        DATA: begin
          if (done) begin
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) dm_rdata <= rdata_eff;
          end
        end
        FETCH: begin
          if (done) begin
            mem_req  <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= rdata_eff;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_pipe = dm_req & ~dm_valid;
  assign stall_if   = stall_pipe | (if_req & ~if_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level schedule and memory model.
module tb_mem_port_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_pipe, stall_if, err;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_pipe(stall_pipe), .stall_if(stall_if), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cfg_wait = 0;
  int          wleft = 0;
  logic        prev_req = 1'b0;
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] exp_dm_rdata = '0;
  logic [31:0] exp_if_rdata = '0;
  logic        exp_err = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: ready after cfg_wait wait cycles; random noise while idle.
  task automatic resp_update();
    if (mem_req && !prev_req) wleft = cfg_wait;
    else if (mem_req && wleft > 0) wleft--;
    prev_req = mem_req;
    if (mem_req) mem_ready = (wleft == 0);
    else         mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = mem_ready ? phys_rd(mem_addr) : $urandom;
    if (mem_req && mem_ready && mem_we)
      phys_mem[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_be);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    resp_update();
  endtask

  // One transaction (data, fetch, or both at once); expected timing from the
  // latency rules: grant at 0, mem_req for 1+w cycles, valid next, fetch after.
  task automatic run_txn(input logic do_d, input logic do_f, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd,
                         input logic [3:0] dbe, input logic [31:0] faddr,
                         input int w, input logic scramble);
    int dv, fv, fg, last, weff, first_v;
    logic dto, in_d, in_f, sp;
    logic [31:0] exp_d_new, exp_f_new;
    logic err_before;
    weff = w;
    dto  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    if (w > TO) begin
      weff = TO;
      dto  = 1'b1;
    end
`endif
    cfg_wait = w;
    tick();
    dm_req = do_d; dm_we = dwe; dm_addr = daddr; dm_wdata = dwd; dm_be = dbe;
    if_req = do_f; if_addr = faddr;
    dv = do_d ? 2 + weff : -1;
    fg = do_d ? dv + 1 : 0;
    fv = do_f ? fg + 2 + weff : -1;
    last = (dv > fv) ? dv : fv;
    first_v = do_d ? dv : fv;
    exp_d_new = '0;
    if (do_d) begin
      if (dwe) begin
        if (!dto) ref_mem[daddr] = merge(ref_rd(daddr), dwd, dbe);
      end else begin
        exp_d_new = dto ? 32'h0 : ref_rd(daddr);
      end
    end
    exp_f_new = dto ? 32'h0 : ref_rd(faddr);
    err_before = exp_err;
    for (int c = 0; ; c++) begin
      #1;
      in_d = do_d && c >= 1 && c <= 1 + weff;
      in_f = do_f && c >= fg + 1 && c <= fg + 1 + weff;
      chk("mem_req", 32'(mem_req), 32'(in_d || in_f));
      if (in_d) begin
        chk("mem_addr_d", mem_addr, daddr);
        chk("mem_we_d", 32'(mem_we), 32'(dwe));
        chk("mem_be_d", 32'(mem_be), 32'(dbe));
        chk("mem_wdata_d", mem_wdata, dwd);
      end
      if (in_f) begin
        chk("mem_addr_f", mem_addr, faddr);
        chk("mem_we_f", 32'(mem_we), 32'h0);
        chk("mem_be_f", 32'(mem_be), 32'hF);
      end
      chk("dm_valid", 32'(dm_valid), 32'(c == dv));
      chk("if_valid", 32'(if_valid), 32'(c == fv));
      if (c == dv && !dwe) exp_dm_rdata = exp_d_new;
      if (c == fv) exp_if_rdata = exp_f_new;
      chk("dm_rdata", dm_rdata, exp_dm_rdata);
      chk("if_rdata", if_rdata, exp_if_rdata);
      sp = dm_req && (c != dv);
      chk("stall_pipe", 32'(stall_pipe), 32'(sp));
      chk("stall_if", 32'(stall_if), 32'(sp || (if_req && c != fv)));
      if (dto && c >= first_v) exp_err = 1'b1;
      chk("err", 32'(err), 32'(err_before || (dto && c >= first_v)));
      if (c == dv) dm_req = 1'b0;
      if (c == fv) if_req = 1'b0;
      if (c >= last) break;
      tick();
      if (scramble) begin
        dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
        dm_be = 4'($urandom);
        if (c + 1 > fg) if_addr = $urandom;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0;
    phys_mem[32'h100] = 32'hCAFE_F00D;
    ref_mem[32'h100]  = 32'hCAFE_F00D;

    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_dm_valid", 32'(dm_valid), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall_pipe", 32'(stall_pipe), 0);
    chk("rst_stall_if", 32'(stall_if), 0);
    dm_req = 1'b1; if_req = 1'b1;
    #1;
    chk("rst_stall_pipe_eq", 32'(stall_pipe), 1);
    chk("rst_stall_if_eq", 32'(stall_if), 1);
    @(posedge clk); #1;
    chk("rst_hold_mem_req", 32'(mem_req), 0);
    dm_req = 1'b0; if_req = 1'b0;
    #2 rst = 1'b0;

    // zero-wait load, collision with two wait states, partial store, latched inputs
    run_txn(1, 0, 0, 32'h100, 32'h0, 4'hF, 32'h0, 0, 0);
    run_txn(1, 1, 0, 32'h100, 32'h0, 4'hF, 32'h40, 2, 0);
    run_txn(1, 0, 1, 32'h100, 32'h1234, 4'b0011, 32'h0, 2, 0);
    run_txn(1, 0, 0, 32'h100, 32'h0, 4'hF, 32'h0, 1, 0);
    run_txn(1, 1, 0, 32'h100, 32'h0, 4'hF, 32'h80, 3, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    run_txn(1, 0, 0, 32'h100, 32'h0, 4'hF, 32'h0, TO + 5, 0);
    run_txn(1, 0, 0, 32'h100, 32'h0, 4'hF, 32'h0, 1, 0);
    run_txn(0, 1, 0, 32'h0, 32'h0, 4'hF, 32'h44, TO, 0);
`endif

    // reset during the third wait state of a load
    cfg_wait = 10;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    tick(); tick(); tick();
    #1;
    chk("mid_mem_req_before", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("mid_mem_req_async", 32'(mem_req), 0);
    chk("mid_dm_valid", 32'(dm_valid), 0);
    chk("mid_stall_pipe", 32'(stall_pipe), 1);
    tick(); #1;
    chk("mid_dm_valid_later", 32'(dm_valid), 0);
    chk("mid_mem_req_later", 32'(mem_req), 0);
    dm_req = 1'b0;
    rst = 1'b0;
    exp_dm_rdata = '0; exp_if_rdata = '0; exp_err = 1'b0;
    run_txn(0, 1, 0, 32'h0, 32'h0, 4'hF, 32'h100, 1, 0);

    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      logic [31:0] da, fa;
      kind = $urandom_range(0, 3);
      da = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      fa = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      run_txn(kind != 2, kind >= 2, (kind == 1) || (kind == 3 && 1'($urandom)),
              da, $urandom, 4'($urandom), fa, $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores presented from the EX/MEM pipeline register).
- Sequences each access with a mem_ready handshake and returns the result.
- Generates the stall signals that freeze the PC/IF_ID, ID_EX and EX_MEM registers while an access is outstanding.

## Interface
Parameters:
- TIMEOUT, 16: watchdog limit in cycles. Used only when the watchdog is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle fetch-complete pulse
- dm_req  in  1  MEM-stage load/store request; held until dm_valid
- dm_we  in  1  1 = store
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_be  in  4  byte enables
- dm_rdata  out  32  load data
- dm_valid  out  1  one-cycle data-complete pulse
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered
- mem_addr  out  32  registered
- mem_wdata  out  32  registered
- mem_be  out  4  registered; all-ones for fetches
- mem_ready  in  1  memory completes the current request in this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1
- stall_pipe  out  1  freeze ID_EX and EX_MEM
- stall_if  out  1  freeze PC and IF_ID
- err  out  1  sticky timeout flag

## Operation
- The FSM has five states: IDLE, DATA, DRESP, FETCH, FRESP.
- IDLE:
  - If dm_req=1: latch dm_* into the mem_* registers with mem_req<=1 and go to DATA.
  - Else if if_req=1: latch if_addr, set mem_we<=0, mem_be<=4'hF, mem_req<=1 and go to FETCH.
  - Else stay in IDLE. Data has fixed priority over fetch.
- DATA:
  - Hold mem_req and all mem_* outputs stable.
  - When mem_ready=1: set mem_req<=0, dm_valid<=1 and go to DRESP.
  - On a load, also set dm_rdata<=mem_rdata. On a store, dm_rdata holds its previous value.
- DRESP:
  - dm_valid=1 for this cycle only, then go to IDLE.
  - Never grants a request: dm_req is still high for the completing instruction.
- FETCH / FRESP: same as DATA / DRESP, using if_rdata and if_valid.
- Stall outputs (combinational):
  - stall_pipe = dm_req & ~dm_valid.
  - stall_if = stall_pipe | (if_req & ~if_valid).
- mem_ready is ignored in IDLE, DRESP and FRESP.
- dm_* and if_* inputs are sampled only at grant. Changes while a request is granted are ignored.

## Timing
- Reset values:
  - All outputs are 0, including err; mem_be is 0.
  - State is IDLE.
  - stall_pipe and stall_if follow their equations.
- Reset asserted mid-transaction drops mem_req asynchronously and discards the access. No valid pulse is produced.
- Latency with mem_ready high in the first mem_req cycle (zero-wait memory):
  - Grant in cycle T, mem_req high in T+1, valid pulse in T+2. Next grant no earlier than T+3.
  - Each wait state adds one cycle.
- Simultaneous dm_req and if_req in IDLE: data is granted, and the fetch waits at least 3 cycles.
- A request that arrives while the FSM is busy is granted in the first IDLE cycle after the current transaction.
- mem_req is never high for two consecutive transactions without an intervening low cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A 5-bit+ counter clears on entry to DATA or FETCH and increments each cycle while mem_ready=0.
  - When the count reaches TIMEOUT, the access completes as if mem_ready had arrived, with rdata forced to 32'h0000_0000.
  - err<=1 at that point and stays set until rst.
- MEM_ARB_TIMEOUT_EN undefined:
  - The FSM waits indefinitely for mem_ready.
  - err is tied to 0 and the counter is absent.

## Test plan
- Zero-wait load: dm_req=1, dm_we=0, dm_addr=0x100, memory returns 0xCAFEF00D.
  - mem_req high in cycle 1 only; dm_valid and dm_rdata=0xCAFEF00D in cycle 2.
  - stall_pipe high in cycles 0–1, low in cycle 2.
- Collision: dm_req and if_req both rise in the same cycle, 2 wait states each.
  - Data transaction first.
  - Fetch mem_req rises only after DRESP.
  - if_valid 9 cycles after start.
  - stall_if high throughout.
- Store: dm_we=1, dm_be=4'b0011, dm_wdata=0x1234.
  - mem_we=1, mem_be=0x3, mem_wdata=0x1234 stable until mem_ready.
  - dm_rdata unchanged.
- Reset mid-DATA: assert rst during wait state 3.
  - mem_req low immediately, no dm_valid.
  - After release, a fresh fetch completes normally.
- Timeout (macro on, TIMEOUT=16): mem_ready held low.
  - dm_valid with dm_rdata=0, and err=1, in the cycle after the timeout completion.
  - err stays 1 across later normal accesses.
- Input change: dm_addr changes while in DATA.
  - mem_addr keeps the value latched at grant.
